// File: rtl/alu_ctrl_seq_if.sv
// alu_ctrl_seq_if: decode-to-ALU control handshake bundle
// master (decode side) drives in_valid/op/func/flush; slave (alu_ctrl_seq) returns
// in_ready, alu_ctrl, out_valid, out_mdu, mdu_busy.
interface alu_ctrl_seq_if #(
    parameter int CTRL_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        op;
    logic [5:0]        func;
    logic              flush;
    logic [CTRL_W-1:0] alu_ctrl;
    logic              out_valid;
    logic              out_mdu;
    logic              mdu_busy;
    modport master (
        output in_valid, op, func, flush,
        input  in_ready, alu_ctrl, out_valid, out_mdu, mdu_busy
    );
    modport slave (
        input  in_valid, op, func, flush,
        output in_ready, alu_ctrl, out_valid, out_mdu, mdu_busy
    );
endinterface

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: sequenced ALU control decoder with multi-cycle MDU busy tracking
// clk, rst (async, active-high); bus (alu_ctrl_seq_if.slave): in_valid/in_ready accept,
// op/func decode, flush kill, alu_ctrl/out_valid/out_mdu completion, mdu_busy.
// ALU_CTRL_MDU_EN defined: MULT/DIV hold the unit busy; undefined: all ops single-cycle.
module alu_ctrl_seq #(
    parameter int CTRL_W     = 5,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst,
    alu_ctrl_seq_if.slave   bus
);
    localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    typedef enum logic {IDLE, BUSY} state_t;
    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              ov_q, ov_d, mdu_q, mdu_d;
    logic [5:0]        code;
    logic              is_mul, is_div, multi;
    logic [CW-1:0]     lat_m1;
    assign code   = (bus.op == 6'h00) ? bus.func :
                    (bus.op == 6'h04 || bus.op == 6'h05) ? 6'h22 :
                    (bus.op == 6'h23 || bus.op == 6'h2b) ? 6'h20 : bus.op;
    assign is_mul = (bus.op == 6'h00) && (bus.func == 6'h18 || bus.func == 6'h19);
    assign is_div = (bus.op == 6'h00) && (bus.func == 6'h1a || bus.func == 6'h1b);
    assign lat_m1 = is_div ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1);
`ifdef ALU_CTRL_MDU_EN
    assign multi  = is_mul | is_div;
`else
    assign multi  = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        ov_d    = 1'b0;
        mdu_d   = mdu_q;
        if (bus.flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == IDLE) begin
            if (bus.in_valid) begin
                ctrl_d  = code[CTRL_W-1:0];
                state_d = multi ? BUSY : IDLE;
                cnt_d   = multi ? lat_m1 : cnt_q;
                ov_d    = ~multi;
                mdu_d   = multi ? mdu_q : 1'b0;
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            state_d = IDLE;
            ov_d    = 1'b1;
            mdu_d   = 1'b1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ctrl_q  <= '0;
            ov_q    <= 1'b0;
            mdu_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            ov_q    <= ov_d;
            mdu_q   <= mdu_d;
        end
    end
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.mdu_busy  = (state_q == BUSY);
    assign bus.alu_ctrl  = ctrl_q;
    assign bus.out_valid = ov_q;
    assign bus.out_mdu   = mdu_q;
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: directed and random checks of alu_ctrl_seq against a cycle model
module tb_alu_ctrl_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
`ifdef ALU_CTRL_MDU_EN
    localparam bit MDU = 1'b1;
`else
    localparam bit MDU = 1'b0;
`endif
    alu_ctrl_seq_if #(.CTRL_W(5)) b5 ();
    alu_ctrl_seq_if #(.CTRL_W(3)) b3 ();
    alu_ctrl_seq #(.CTRL_W(5), .MUL_CYCLES(4), .DIV_CYCLES(32)) dut5 (.clk(clk), .rst(rst), .bus(b5));
    alu_ctrl_seq #(.CTRL_W(3), .MUL_CYCLES(1), .DIV_CYCLES(3))  dut3 (.clk(clk), .rst(rst), .bus(b3));
    always #5 clk = ~clk;
    int         wid[2] = '{5, 3};
    int         mlat[2] = '{4, 1};
    int         dlat[2] = '{32, 3};
    int         rem[2];
    logic [7:0] ectrl[2];
    logic       eov[2];
    logic       emdu[2];
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            rem[i] = 0; ectrl[i] = 8'h00; eov[i] = 1'b0; emdu[i] = 1'b0;
        end
    endtask
    function automatic logic [5:0] spec_code(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'h00) return f;
        if (o == 6'h04 || o == 6'h05) return 6'h22;
        if (o == 6'h23 || o == 6'h2b) return 6'h20;
        return o;
    endfunction
    task automatic model_edge(input logic iv, input logic [5:0] o, input logic [5:0] f, input logic fl);
        int lat;
        for (int i = 0; i < 2; i++) begin
            if (fl) begin
                rem[i] = 0; eov[i] = 1'b0;
            end else if (rem[i] > 0) begin
                rem[i]--;
                eov[i] = (rem[i] == 0);
                if (rem[i] == 0) emdu[i] = 1'b1;
            end else if (iv) begin
                ectrl[i] = 8'(int'(spec_code(o, f)) % (1 << wid[i]));
                lat = 0;
                if (MDU && o == 6'h00 && (f == 6'h18 || f == 6'h19)) lat = mlat[i];
                if (MDU && o == 6'h00 && (f == 6'h1a || f == 6'h1b)) lat = dlat[i];
                if (lat > 0) begin
                    rem[i] = lat; eov[i] = 1'b0;
                end else begin
                    eov[i] = 1'b1; emdu[i] = 1'b0;
                end
            end else begin
                eov[i] = 1'b0;
            end
        end
    endtask
    task automatic check_all(input string tag);
        chk({tag, ".ctrl5"},  8'(b5.alu_ctrl), ectrl[0]);
        chk({tag, ".ov5"},    8'(b5.out_valid), 8'(eov[0]));
        chk({tag, ".busy5"},  8'(b5.mdu_busy), 8'(rem[0] > 0));
        chk({tag, ".rdy5"},   8'(b5.in_ready), 8'(rem[0] == 0));
        if (eov[0]) chk({tag, ".mdu5"}, 8'(b5.out_mdu), 8'(emdu[0]));
        chk({tag, ".ctrl3"},  8'(b3.alu_ctrl), ectrl[1]);
        chk({tag, ".ov3"},    8'(b3.out_valid), 8'(eov[1]));
        chk({tag, ".busy3"},  8'(b3.mdu_busy), 8'(rem[1] > 0));
        chk({tag, ".rdy3"},   8'(b3.in_ready), 8'(rem[1] == 0));
        if (eov[1]) chk({tag, ".mdu3"}, 8'(b3.out_mdu), 8'(emdu[1]));
    endtask
    task automatic step(input string tag, input logic iv, input logic [5:0] o, input logic [5:0] f, input logic fl);
        @(negedge clk);
        b5.in_valid = iv; b5.op = o; b5.func = f; b5.flush = fl;
        b3.in_valid = iv; b3.op = o; b3.func = f; b3.flush = fl;
        @(posedge clk);
        model_edge(iv, o, f, fl);
        #1;
        check_all(tag);
    endtask
    initial begin
        logic [5:0] ro, rf;
        b5.in_valid = 1'b0; b5.op = '0; b5.func = '0; b5.flush = 1'b0;
        b3.in_valid = 1'b0; b3.op = '0; b3.func = '0; b3.flush = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;
        step("idle", 1'b0, 6'h00, 6'h00, 1'b0);
        step("div", 1'b1, 6'h00, 6'h1a, 1'b0);
        for (int i = 0; i < 8; i++) step("div_wait", 1'b0, 6'h00, 6'h00, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        check_all("rst_mid");
        chk("rst_mid.rdy", 8'(b5.in_ready), 8'h01);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step("post_rst", 1'b0, 6'h00, 6'h00, 1'b0);
        step("b2b_add", 1'b1, 6'h00, 6'h20, 1'b0);
        chk("b2b_add.lit", 8'(b5.alu_ctrl), 8'h00);
        step("b2b_beq", 1'b1, 6'h04, 6'h00, 1'b0);
        chk("b2b_beq.lit", 8'(b5.alu_ctrl), 8'h02);
        step("b2b_lw", 1'b1, 6'h23, 6'h00, 1'b0);
        chk("b2b_lw.lit", 8'(b5.alu_ctrl), 8'h00);
        chk("b2b_lw.ov", 8'(b5.out_valid), 8'h01);
        step("sw", 1'b1, 6'h2b, 6'h00, 1'b0);
        chk("w3_sw.lit", 8'(b3.alu_ctrl), 8'h00);
        step("ori", 1'b1, 6'h0d, 6'h00, 1'b0);
        chk("w3_ori.lit", 8'(b3.alu_ctrl), 8'h05);
        step("mul", 1'b1, 6'h00, 6'h18, 1'b0);
        for (int i = 0; i < 5; i++) step("mul_hold", 1'b1, 6'h0d, 6'h00, 1'b0);
        step("div2", 1'b1, 6'h00, 6'h1a, 1'b0);
`ifndef ALU_CTRL_MDU_EN
        chk("nomdu.ctrl", 8'(b5.alu_ctrl), 8'h1a);
        chk("nomdu.busy", 8'(b5.mdu_busy), 8'h00);
`endif
        for (int i = 0; i < 4; i++) step("div2_wait", 1'b0, 6'h00, 6'h00, 1'b0);
        step("flush", 1'b1, 6'h00, 6'h20, 1'b1);
        chk("flush.ov", 8'(b5.out_valid), 8'h00);
        for (int i = 0; i < 3; i++) step("post_flush", 1'b0, 6'h00, 6'h00, 1'b0);
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(7))
                0, 1, 2: ro = 6'h00;
                3:       ro = 6'h04;
                4:       ro = 6'h05;
                5:       ro = 6'h23;
                6:       ro = 6'h2b;
                default: ro = 6'($urandom);
            endcase
            case ($urandom_range(7))
                0: rf = 6'h18;
                1: rf = 6'h19;
                2: rf = 6'h1a;
                3: rf = 6'h1b;
                4: rf = 6'h20;
                5: rf = 6'h22;
                default: rf = 6'($urandom);
            endcase
            step("rand", $urandom_range(3) != 0, ro, rf, $urandom_range(15) == 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
